instr_encoder: RTL and testbench

- Inverse of the core's instruction decoder: takes a decoded micro-op (instruction class, 4-bit ALU op code, register indices, immediate) and emits 32-bit RV32I machine words.
- Sits between the test-program generator / boot ROM builder and the instruction memory write port.
- Has a one-entry registered output with valid/ready handshake.
- Expands the LI pseudo-op into LUI+ADDI over two beats via a small FSM.

---
 rtl/core_pkg.sv | 57 +++++
 rtl/instr_format_pack.sv | 30 +++
 rtl/instr_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encoding constants for the RV32I decoder/encoder pair: ALU codes, opcodes,
// micro-op kinds and the ALU-code to funct3/funct7 map.
package core_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    KindR, KindIAlu, KindLoad, KindStore, KindBranch, KindJal, KindJalr, KindLi
  } req_kind_e;

  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;

  typedef struct packed {
    logic       ok;
    logic       shift;
    logic [2:0] f3;
    logic [6:0] f7;
  } alu_enc_t;

  function automatic alu_enc_t alu_encode(input logic [3:0] code);
    alu_enc_t r;
    r = '{ok: 1'b1, shift: 1'b0, f3: 3'b000, f7: 7'h00};
    case (code)
      ALU_ADD:  r.f3 = 3'b000;
      ALU_SUB:  begin r.f3 = 3'b000; r.f7 = 7'h20; end
      ALU_AND:  r.f3 = 3'b111;
      ALU_OR:   r.f3 = 3'b110;
      ALU_XOR:  r.f3 = 3'b100;
      ALU_SLL:  begin r.f3 = 3'b001; r.shift = 1'b1; end
      ALU_SRL:  begin r.f3 = 3'b101; r.shift = 1'b1; end
      ALU_SRA:  begin r.f3 = 3'b101; r.f7 = 7'h20; r.shift = 1'b1; end
      ALU_SLT:  r.f3 = 3'b010;
      ALU_SLTU: r.f3 = 3'b011;
      default:  r.ok = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_format_pack.sv
// Combinational packer: places already-resolved fields into an R/I/S/B/U/J RV32I word.
module instr_format_pack
  import core_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  f3_i,
  input  logic [6:0]  f7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    case (fmt_i)
      FmtR: word_o = {f7_i, rs2_i, rs1_i, f3_i, rd_i, opcode_i};
      FmtI: word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, opcode_i};
      FmtS: word_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], opcode_i};
      FmtB: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i, imm_i[4:1], imm_i[11],
                      opcode_i};
      FmtU: word_o = {imm_i[31:12], rd_i, opcode_i};
      FmtJ: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Micro-op to RV32I encoder with a one-entry output register; LI expands to LUI+ADDI
// through a two-state FSM.
module instr_encoder
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_kind,
  input  logic [3:0]      req_alu_op,
  input  logic [2:0]      req_f3,
  input  logic [4:0]      req_rd,
  input  logic [4:0]      req_rs1,
  input  logic [4:0]      req_rs2,
  input  logic [XLEN-1:0] req_imm,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic            err
);

  typedef enum logic [0:0] {StIdle, StLi2} state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [4:0]  li_rd_q, li_rd_d;
  logic [11:0] li_lo_q, li_lo_d;

  req_kind_e   kind;
  alu_enc_t    alu;
  logic signed [31:0] imm_s;
  logic        fits12, fits_b, fits_j, accept, enc_err, li_split;
  logic [19:0] li_hi;
  fmt_e        fmt;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  p_rd, p_rs1, p_rs2;
  logic [31:0] p_imm, word, li2_word;

  assign kind   = req_kind_e'(req_kind);
  assign alu    = alu_encode(req_alu_op);
  assign imm_s  = req_imm;
  assign fits12 = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign fits_b = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !req_imm[0];
  assign fits_j = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !req_imm[0];
  // Rounding the upper part makes the low 12 bits a signed ADDI that lands on imm.
  assign li_hi  = req_imm[31:12] + {19'b0, req_imm[11]};

  assign req_ready = (state_q == StIdle) && (!valid_q || instr_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    fmt      = FmtR;
    opcode   = OP_R;
    f3       = req_f3;
    f7       = alu.f7;
    p_rd     = req_rd;
    p_rs1    = req_rs1;
    p_rs2    = req_rs2;
    p_imm    = req_imm;
    enc_err  = 1'b0;
    li_split = 1'b0;
    unique case (kind)
      KindR: begin
        f3      = alu.f3;
        enc_err = !alu.ok;
      end
      KindIAlu: begin
        fmt    = FmtI;
        opcode = OP_IMM;
        f3     = alu.f3;
        if (alu.shift) p_imm = {20'b0, alu.f7, req_imm[4:0]};
        enc_err = !alu.ok || (req_alu_op == ALU_SUB) || (!alu.shift && !fits12);
      end
      KindLoad: begin
        fmt     = FmtI;
        opcode  = OP_LOAD;
        enc_err = !fits12;
      end
      KindStore: begin
        fmt     = FmtS;
        opcode  = OP_STORE;
        enc_err = !fits12;
      end
      KindBranch: begin
        fmt     = FmtB;
        opcode  = OP_BRANCH;
        enc_err = !fits_b;
      end
      KindJal: begin
        fmt     = FmtJ;
        opcode  = OP_JAL;
        enc_err = !fits_j;
      end
      KindJalr: begin
        fmt    = FmtI;
        opcode = OP_JALR;
        f3     = 3'b000;
      end
      KindLi: begin
        if (fits12) begin
          fmt    = FmtI;
          opcode = OP_IMM;
          f3     = 3'b000;
          p_rs1  = 5'd0;
        end else begin
          fmt      = FmtU;
          opcode   = OP_LUI;
          p_imm    = {li_hi, 12'b0};
          li_split = |req_imm[11:0];
        end
      end
      default: enc_err = 1'b1;
    endcase
  end

  instr_format_pack u_pack (
    .fmt_i    (fmt),
    .opcode_i (opcode),
    .f3_i     (f3),
    .f7_i     (f7),
    .rd_i     (p_rd),
    .rs1_i    (p_rs1),
    .rs2_i    (p_rs2),
    .imm_i    (p_imm),
    .word_o   (word)
  );

  instr_format_pack u_pack_li2 (
    .fmt_i    (FmtI),
    .opcode_i (OP_IMM),
    .f3_i     (3'b000),
    .f7_i     (7'h00),
    .rd_i     (li_rd_q),
    .rs1_i    (li_rd_q),
    .rs2_i    (5'd0),
    .imm_i    ({{20{li_lo_q[11]}}, li_lo_q}),
    .word_o   (li2_word)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q && !instr_ready;
    err_d   = 1'b0;
    li_rd_d = li_rd_q;
    li_lo_d = li_lo_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (enc_err) begin
            err_d = 1'b1;
          end else begin
            instr_d = word;
            valid_d = 1'b1;
            li_rd_d = req_rd;
            li_lo_d = req_imm[11:0];
            if (li_split) state_d = StLi2;
          end
        end
      end
      StLi2: begin
        if (valid_q && instr_ready) begin
          instr_d = li2_word;
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      li_rd_q <= '0;
      li_lo_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      li_rd_q <= li_rd_d;
      li_lo_q <= li_lo_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors, literal checks and a per-cycle scoreboard
// fed by an arithmetic model of the encoding rules.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_kind = '0;
  logic [3:0]  req_alu_op = '0;
  logic [2:0]  req_f3 = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_mode = 1'b0;

  logic [31:0] exp_q[$];
  bit          err_exp = 1'b0;

  instr_encoder #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .req_alu_op  (req_alu_op),
    .req_f3      (req_f3),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_imm     (req_imm),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Words an accepted micro-op must produce, in order; e=1 means dropped with err.
  function automatic void model(input int kind, input int alu, input int f3, input int rd,
                                input int rs1, input int rs2, input logic [31:0] imm,
                                output int n, output logic [31:0] w0, output logic [31:0] w1,
                                output bit e);
    int s;
    bit ok, shift;
    logic [6:0] f7a;
    logic [2:0] f3a, f;
    logic [4:0] d, a, b;
    logic [31:0] hi, lo;
    s = $signed(imm);
    d = rd[4:0]; a = rs1[4:0]; b = rs2[4:0]; f = f3[2:0];
    ok = 1; shift = 0; f7a = 7'h00; f3a = 3'b000;
    case (alu)
      2:  f3a = 3'd0;
      6:  begin f3a = 3'd0; f7a = 7'h20; end
      0:  f3a = 3'd7;
      1:  f3a = 3'd6;
      4:  f3a = 3'd4;
      5:  begin f3a = 3'd1; shift = 1; end
      8:  begin f3a = 3'd5; shift = 1; end
      9:  begin f3a = 3'd5; f7a = 7'h20; shift = 1; end
      7:  f3a = 3'd2;
      10: f3a = 3'd3;
      default: ok = 0;
    endcase
    n = 1; e = 0; w0 = '0; w1 = '0;
    case (kind)
      0: if (!ok) e = 1; else w0 = {f7a, b, a, f3a, d, 7'h33};
      1: if (!ok || alu == 6) e = 1;
         else if (shift) w0 = {f7a, imm[4:0], a, f3a, d, 7'h13};
         else if (s < -2048 || s > 2047) e = 1;
         else w0 = {imm[11:0], a, f3a, d, 7'h13};
      2: if (s < -2048 || s > 2047) e = 1; else w0 = {imm[11:0], a, f, d, 7'h03};
      3: if (s < -2048 || s > 2047) e = 1;
         else w0 = {imm[11:5], b, a, f, imm[4:0], 7'h23};
      4: if (s[0] || s < -4096 || s > 4094) e = 1;
         else w0 = {imm[12], imm[10:5], b, a, f, imm[4:1], imm[11], 7'h63};
      5: if (s[0] || s < -1048576 || s > 1048574) e = 1;
         else w0 = {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'h6f};
      6: w0 = {imm[11:0], a, 3'b000, d, 7'h67};
      default: begin
        if (s >= -2048 && s <= 2047) begin
          w0 = {imm[11:0], 5'd0, 3'b000, d, 7'h13};
        end else begin
          hi = (imm + 32'h800) >> 12;
          lo = imm - (hi << 12);
          w0 = {hi[19:0], d, 7'h37};
          if (lo != 0) begin
            n  = 2;
            w1 = {lo[11:0], d, 3'b000, d, 7'h13};
          end
        end
      end
    endcase
    if (e) n = 0;
  endfunction

  // Scoreboard: runs every falling edge, checks outputs, then records the handshakes
  // that the coming rising edge will perform.
  always @(negedge clk) begin
    int n;
    logic [31:0] w0, w1;
    bit e;
    if (!rst_n) begin
      exp_q.delete();
      err_exp = 1'b0;
    end else begin
      cmp("sb_valid", {31'b0, instr_valid}, {31'b0, exp_q.size() != 0});
      cmp("sb_err", {31'b0, err}, {31'b0, err_exp});
      cmp("sb_ready", {31'b0, req_ready},
          {31'b0, (exp_q.size() <= 1) && (exp_q.size() == 0 || instr_ready)});
      if (instr_valid && exp_q.size() != 0) begin
        cmp("sb_instr", instr, exp_q[0]);
        if (instr_ready) void'(exp_q.pop_front());
      end
      err_exp = 1'b0;
      if (req_valid && req_ready) begin
        model(int'(req_kind), int'(req_alu_op), int'(req_f3), int'(req_rd), int'(req_rs1),
              int'(req_rs2), req_imm, n, w0, w1, e);
        if (e) err_exp = 1'b1;
        if (n >= 1) exp_q.push_back(w0);
        if (n == 2) exp_q.push_back(w1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting rising edge.
  task automatic send(input int kind, input int alu, input int f3, input int rd, input int rs1,
                      input int rs2, input logic [31:0] imm);
    req_kind = kind[2:0]; req_alu_op = alu[3:0]; req_f3 = f3[2:0];
    req_rd = rd[4:0]; req_rs1 = rs1[4:0]; req_rs2 = rs2[4:0]; req_imm = imm;
    req_valid = 1'b1;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (req_ready) break;
      if (i > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: req_ready stuck at 0 for kind %0d", kind);
        break;
      end
      @(posedge clk);
      #1;
      if (rand_mode) instr_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (rand_mode) instr_ready = ($urandom_range(0, 3) != 0);
  endtask

  typedef struct {
    int kind; int alu; int f3; int rd; int rs1; int rs2; logic [31:0] imm;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int n;
    logic [31:0] w0, w1;
    bit e;

    // Literal pins on the model itself.
    model(0, 2, 0, 3, 1, 2, 32'd0, n, w0, w1, e);
    cmp("model_add", w0, 32'h002081B3);
    model(3, 0, 2, 0, 2, 5, 32'd8, n, w0, w1, e);
    cmp("model_store", w0, 32'h00512423);
    model(7, 0, 0, 10, 0, 0, 32'h12345678, n, w0, w1, e);
    cmp("model_li_n", n, 2);
    cmp("model_li_w1", w1, 32'h67850513);
    model(7, 0, 0, 4, 0, 0, -32'sd5, n, w0, w1, e);
    cmp("model_li_neg", w0, 32'hFFB00213);
    model(4, 0, 0, 0, 1, 2, 32'd3, n, w0, w1, e);
    cmp("model_br_odd_err", {31'b0, e}, 32'd1);

    @(posedge clk);
    #1;
    cmp("rst_valid_low", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmp("rst_instr", instr, 32'd0);
    cmp("rst_err", {31'b0, err}, 32'd0);
    cmp("rst_ready", {31'b0, req_ready}, 32'd1);

    send(0, 2, 0, 3, 1, 2, 32'd0);
    cmp("add", instr, 32'h002081B3);
    send(0, 6, 0, 5, 6, 7, 32'd0);
    cmp("sub", instr, 32'h407302B3);
    send(3, 0, 2, 0, 2, 5, 32'd8);
    cmp("store", instr, 32'h00512423);
    idle(2);
    send(1, 6, 0, 1, 1, 0, 32'd1);
    cmp("ialu_sub_err", {31'b0, err}, 32'd1);
    cmp("ialu_sub_noword", {31'b0, instr_valid}, 32'd0);
    idle(1);
    cmp("err_one_cycle", {31'b0, err}, 32'd0);

    send(7, 0, 0, 10, 0, 0, 32'h12345678);
    cmp("li_lui", instr, 32'h12345537);
    cmp("li_busy", {31'b0, req_ready}, 32'd0);
    idle(1);
    cmp("li_addi", instr, 32'h67850513);
    send(7, 0, 0, 1, 0, 0, 32'h00000FFF);
    cmp("li_fff_lui", instr, 32'h000010B7);
    idle(1);
    cmp("li_fff_addi", instr, 32'hFFF08093);
    send(7, 0, 0, 2, 0, 0, 32'h00005000);
    cmp("li_5000", instr, 32'h00005137);
    cmp("li_5000_ready", {31'b0, req_ready}, 32'd1);
    send(7, 0, 0, 4, 0, 0, -32'sd5);
    cmp("li_neg5", instr, 32'hFFB00213);
    idle(2);

    // Downstream stall with the second LI beat pending.
    instr_ready = 1'b0;
    send(7, 0, 0, 10, 0, 0, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      cmp("stall_hold", instr, 32'h12345537);
      cmp("stall_ready", {31'b0, req_ready}, 32'd0);
    end
    instr_ready = 1'b1;
    idle(1);
    cmp("stall_release", instr, 32'h67850513);
    cmp("stall_release_v", {31'b0, instr_valid}, 32'd1);
    idle(2);

    // Reset while the ADDI beat is pending.
    instr_ready = 1'b0;
    send(7, 0, 0, 10, 0, 0, 32'h12345678);
    #2 rst_n = 1'b0;
    #1;
    cmp("li2_rst_valid", {31'b0, instr_valid}, 32'd0);
    cmp("li2_rst_instr", instr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    cmp("li2_rst_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      cmp("li2_rst_no_addi", {31'b0, instr_valid}, 32'd0);
    end

    send(4, 0, 0, 0, 1, 2, 32'd3);
    cmp("branch_odd_err", {31'b0, err}, 32'd1);
    idle(2);

    // Boundary vectors with a randomly stalling consumer, checked by the scoreboard.
    tbl.push_back('{1, 2, 0, 7, 8, 0, 32'd2047});
    tbl.push_back('{1, 2, 0, 7, 8, 0, 32'd2048});
    tbl.push_back('{1, 0, 0, 7, 8, 0, -32'sd2048});
    tbl.push_back('{1, 5, 0, 9, 9, 0, 32'd31});
    tbl.push_back('{1, 9, 0, 9, 9, 0, 32'h0000_0FE3});
    tbl.push_back('{0, 3, 0, 1, 2, 3, 32'd0});
    tbl.push_back('{0, 10, 0, 31, 30, 29, 32'd0});
    tbl.push_back('{2, 0, 4, 5, 6, 0, -32'sd2049});
    tbl.push_back('{2, 0, 2, 5, 6, 0, -32'sd4});
    tbl.push_back('{3, 0, 0, 0, 3, 4, 32'd2047});
    tbl.push_back('{4, 0, 1, 0, 3, 4, 32'd4094});
    tbl.push_back('{4, 0, 5, 0, 3, 4, -32'sd4096});
    tbl.push_back('{4, 0, 0, 0, 3, 4, 32'd4096});
    tbl.push_back('{5, 0, 0, 1, 0, 0, 32'd1048574});
    tbl.push_back('{5, 0, 0, 1, 0, 0, -32'sd1048576});
    tbl.push_back('{5, 0, 0, 1, 0, 0, 32'd1048576});
    tbl.push_back('{5, 0, 0, 1, 0, 0, 32'd6});
    tbl.push_back('{6, 0, 3, 1, 5, 0, 32'h0000_0123});
    tbl.push_back('{7, 0, 0, 0, 0, 0, 32'h0000_0800});
    tbl.push_back('{7, 0, 0, 6, 0, 0, 32'h7FFF_F800});
    tbl.push_back('{7, 0, 0, 6, 0, 0, 32'h8000_0000});
    tbl.push_back('{7, 0, 0, 6, 0, 0, 32'hFFFF_F7FF});
    rand_mode = 1'b1;
    foreach (tbl[i]) begin
      send(tbl[i].kind, tbl[i].alu, tbl[i].f3, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
    end
    rand_mode = 1'b0;
    instr_ready = 1'b1;
    idle(4);
    cmp("drained", {31'b0, instr_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
